// File: rtl/seven_seg_scan_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scan_mux_if
// Brief    : Digit-load and segment-drive bundle for seven_seg_scan_mux.
// Revision : 1.0 - initial release
// ============================================================================
interface seven_seg_scan_mux_if #(
    parameter int NDIG = 4
);
    logic [4*NDIG-1:0] bcd_in;
    logic [NDIG-1:0]   dp_in;
    logic              load;
    logic              pending;
    logic              frame_start;
    logic              segA;
    logic              segB;
    logic              segC;
    logic              segD;
    logic              segE;
    logic              segF;
    logic              segG;
    logic              segDP;
    logic [NDIG-1:0]   dig;

    modport master (
        output bcd_in, dp_in, load,
        input  pending, frame_start,
        input  segA, segB, segC, segD, segE, segF, segG, segDP, dig
    );

    modport slave (
        input  bcd_in, dp_in, load,
        output pending, frame_start,
        output segA, segB, segC, segD, segE, segF, segG, segDP, dig
    );
endinterface
`default_nettype wire

// File: rtl/seven_seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scan_mux
// Brief    : Double-buffered, time-multiplexed BCD 7-segment scan driver with
//            per-slot dead time. Optional macro LEADING_ZERO_BLANK_EN blanks
//            leading zero digits (digit 0 is always shown).
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_scan_mux #(
    parameter int NDIG      = 4,
    parameter int DIV_W     = 14,
    parameter int BLANK_CYC = 64
) (
    input  wire logic           CLK,
    input  wire logic           RST,
    seven_seg_scan_mux_if.slave bus
);

    localparam int                IDX_W       = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0]  c_LAST_IDX  = IDX_W'(NDIG - 1);
    localparam logic [DIV_W-1:0]  c_BLANK_CYC = DIV_W'(BLANK_CYC);

    logic [DIV_W-1:0]          r_cnt;
    logic [IDX_W-1:0]          r_idx;
    logic [NDIG-1:0][3:0]      r_pendBcd;
    logic [NDIG-1:0][3:0]      r_actBcd;
    logic [NDIG-1:0]           r_pendDp;
    logic [NDIG-1:0]           r_actDp;
    logic                      r_pending;
    logic                      r_frameStart;
    logic [NDIG-1:0]           r_dig;
    logic [6:0]                r_seg;
    logic                      r_segDp;

    logic                      w_slotEnd;
    logic                      w_frameEnd;
    logic                      w_inBlank;
    logic [NDIG-1:0]           w_digOh;
    logic [3:0]                w_curBcd;
    logic                      w_curDp;
    logic                      w_blankLead;
    logic [6:0]                w_curSeg;

    // Segment order is {A,B,C,D,E,F,G}; non-decimal codes go dark.
    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    assign w_slotEnd  = &r_cnt;
    assign w_frameEnd = w_slotEnd && (r_idx == c_LAST_IDX);
    assign w_inBlank  = (r_cnt < c_BLANK_CYC);
    assign w_curBcd   = r_actBcd[r_idx];
    assign w_curDp    = r_actDp[r_idx];

    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digOh
        assign w_digOh[gi] = (r_idx == IDX_W'(gi));
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [NDIG-1:0] w_zeroFrom;
    logic            w_zeroRun;

    // w_zeroFrom[i] is set when digit i and every digit above it are zero.
    always_comb begin
        w_zeroRun  = 1'b1;
        w_zeroFrom = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            w_zeroRun     = w_zeroRun & (r_actBcd[i] == 4'd0);
            w_zeroFrom[i] = w_zeroRun;
        end
    end

    assign w_blankLead = (r_idx != '0) && w_zeroFrom[r_idx];
`else
    assign w_blankLead = 1'b0;
`endif

    assign w_curSeg = w_blankLead ? 7'b0000000 : decode(w_curBcd);

    // Scan timebase: prescaler plus digit index.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_slotEnd) begin
                r_idx <= (r_idx == c_LAST_IDX) ? '0 : r_idx + 1'b1;
            end
        end
    end

    // Transfer reads the pending buffer's pre-edge value, so a coincident
    // load is held over to the following frame.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pendBcd <= '0;
            r_pendDp  <= '0;
            r_actBcd  <= '0;
            r_actDp   <= '0;
            r_pending <= 1'b0;
        end else begin
            if (w_frameEnd && r_pending) begin
                r_actBcd <= r_pendBcd;
                r_actDp  <= r_pendDp;
            end
            if (bus.load) begin
                r_pendBcd <= bus.bcd_in;
                r_pendDp  <= bus.dp_in;
                r_pending <= 1'b1;
            end else if (w_frameEnd) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_frameStart <= 1'b0;
            r_dig        <= '0;
            r_seg        <= '0;
            r_segDp      <= 1'b0;
        end else begin
            r_frameStart <= w_frameEnd;
            if (w_inBlank) begin
                r_dig   <= '0;
                r_seg   <= '0;
                r_segDp <= 1'b0;
            end else begin
                r_dig   <= w_digOh;
                r_seg   <= w_curSeg;
                r_segDp <= w_curDp;
            end
        end
    end

    assign bus.pending     = r_pending;
    assign bus.frame_start = r_frameStart;
    assign bus.dig         = r_dig;
    assign bus.segA        = r_seg[6];
    assign bus.segB        = r_seg[5];
    assign bus.segC        = r_seg[4];
    assign bus.segD        = r_seg[3];
    assign bus.segE        = r_seg[2];
    assign bus.segF        = r_seg[1];
    assign bus.segG        = r_seg[0];
    assign bus.segDP       = r_segDp;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_scan_mux
// Brief    : Self-checking bench for seven_seg_scan_mux (NDIG=4, DIV_W=4,
//            BLANK_CYC=2) with a frame-position reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_mux;

    localparam int NDIG      = 4;
    localparam int DIV_W     = 4;
    localparam int BLANK_CYC = 2;
    localparam int SLOT      = 1 << DIV_W;
    localparam int FRAME     = NDIG * SLOT;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    seven_seg_scan_mux_if #(.NDIG(NDIG)) bus ();

    seven_seg_scan_mux #(
        .NDIG      (NDIG),
        .DIV_W     (DIV_W),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [6:0] segTab [16];

    // Model state: position within the frame since reset release, plus buffers.
    int         pos;
    logic [3:0] mAct  [NDIG];
    logic [3:0] mPend [NDIG];
    logic [3:0] mActDp, mPendDp;
    bit         mPending;
    logic [3:0] expDig;
    logic [6:0] expSeg;
    logic       expDp, expFs;

    typedef struct packed {
        logic [15:0]     bcd;
        logic [3:0]      dp;
        logic [3:0][6:0] segP;
        logic [3:0][6:0] segL;
    } vec_t;
    vec_t tbl [7];

    function automatic logic [6:0] segNow();
        return {bus.segA, bus.segB, bus.segC, bus.segD, bus.segE, bus.segF, bus.segG};
    endfunction

    function automatic logic [6:0] modelSeg(input int slot);
        logic [6:0] s;
        s = segTab[mAct[slot]];
`ifdef LEADING_ZERO_BLANK_EN
        if (slot >= 1) begin
            bit allZero;
            allZero = 1'b1;
            for (int k = slot; k < NDIG; k++) if (mAct[k] != 4'd0) allZero = 1'b0;
            if (allZero) s = 7'b0000000;
        end
`endif
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        int  p, slot, off;
        bit  fe;
        @(posedge CLK);
        if (RST) begin
            for (int k = 0; k < NDIG; k++) begin
                mAct[k]  = 4'd0;
                mPend[k] = 4'd0;
            end
            mActDp   = '0;
            mPendDp  = '0;
            mPending = 1'b0;
            expDig   = '0;
            expSeg   = '0;
            expDp    = 1'b0;
            expFs    = 1'b0;
            pos      = 0;
        end else begin
            p    = pos % FRAME;
            slot = p / SLOT;
            off  = p % SLOT;
            fe   = (p == FRAME - 1);
            if (off < BLANK_CYC) begin
                expDig = '0;
                expSeg = '0;
                expDp  = 1'b0;
            end else begin
                expDig = 4'(1 << slot);
                expSeg = modelSeg(slot);
                expDp  = mActDp[slot];
            end
            expFs = fe;
            if (fe && mPending) begin
                for (int k = 0; k < NDIG; k++) mAct[k] = mPend[k];
                mActDp = mPendDp;
            end
            if (bus.load) begin
                for (int k = 0; k < NDIG; k++) mPend[k] = bus.bcd_in[k*4 +: 4];
                mPendDp  = bus.dp_in;
                mPending = 1'b1;
            end else if (fe) begin
                mPending = 1'b0;
            end
            pos++;
        end
        #1;
        check("model_dig",         32'(bus.dig),         32'(expDig));
        check("model_seg",         32'(segNow()),        32'(expSeg));
        check("model_segDP",       32'(bus.segDP),       32'(expDp));
        check("model_frame_start", 32'(bus.frame_start), 32'(expFs));
        check("model_pending",     32'(bus.pending),     32'(mPending));
    endtask

    task automatic waitFs();
        bit found;
        found = 1'b0;
        for (int n = 0; n < 2 * FRAME + 8 && !found; n++) begin
            tick();
            if (bus.frame_start) found = 1'b1;
        end
        check("frame_start_seen", 32'(found), 32'd1);
    endtask

    task automatic doLoad(input logic [15:0] bcd, input logic [3:0] dp);
        bus.bcd_in = bcd;
        bus.dp_in  = dp;
        bus.load   = 1'b1;
        tick();
        bus.load   = 1'b0;
    endtask

    initial begin
        segTab[0]  = 7'b1111110; segTab[1]  = 7'b0110000;
        segTab[2]  = 7'b1101101; segTab[3]  = 7'b1111001;
        segTab[4]  = 7'b0110011; segTab[5]  = 7'b1011011;
        segTab[6]  = 7'b1011111; segTab[7]  = 7'b1110000;
        segTab[8]  = 7'b1111111; segTab[9]  = 7'b1111011;
        for (int k = 10; k < 16; k++) segTab[k] = 7'b0000000;

        tbl[0] = '{bcd: 16'h1234, dp: 4'b0010,
                   segP: {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011},
                   segL: {7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011}};
        tbl[1] = '{bcd: 16'h5678, dp: 4'b0000,
                   segP: {7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111},
                   segL: {7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111}};
        tbl[2] = '{bcd: 16'h00A0, dp: 4'b0010,
                   segP: {7'b1111110, 7'b1111110, 7'b0000000, 7'b1111110},
                   segL: {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}};
        tbl[3] = '{bcd: 16'h0070, dp: 4'b0000,
                   segP: {7'b1111110, 7'b1111110, 7'b1110000, 7'b1111110},
                   segL: {7'b0000000, 7'b0000000, 7'b1110000, 7'b1111110}};
        tbl[4] = '{bcd: 16'h0000, dp: 4'b0001,
                   segP: {7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110},
                   segL: {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}};
        tbl[5] = '{bcd: 16'h9009, dp: 4'b1001,
                   segP: {7'b1111011, 7'b1111110, 7'b1111110, 7'b1111011},
                   segL: {7'b1111011, 7'b1111110, 7'b1111110, 7'b1111011}};
        tbl[6] = '{bcd: 16'h0100, dp: 4'b1000,
                   segP: {7'b1111110, 7'b0110000, 7'b1111110, 7'b1111110},
                   segL: {7'b0000000, 7'b0110000, 7'b1111110, 7'b1111110}};

        pos = 0; mPending = 1'b0; mActDp = '0; mPendDp = '0;
        for (int k = 0; k < NDIG; k++) begin mAct[k] = 4'd0; mPend[k] = 4'd0; end

        // Reset held three cycles with a load request that must be ignored.
        RST        = 1'b1;
        bus.load   = 1'b1;
        bus.bcd_in = 16'h8888;
        bus.dp_in  = 4'b1111;
        repeat (3) begin
            tick();
            check("rst_dig",     32'(bus.dig),     32'd0);
            check("rst_seg",     32'(segNow()),    32'd0);
            check("rst_pending", 32'(bus.pending), 32'd0);
        end
        RST      = 1'b0;
        bus.load = 1'b0;
        tick(); check("post_rst_gap0", 32'(bus.dig), 32'd0);
        tick(); check("post_rst_gap1", 32'(bus.dig), 32'd0);
        tick();
        check("post_rst_dig0", 32'(bus.dig),  32'b0001);
        check("post_rst_seg0", 32'(segNow()), 32'b1111110);

        // Scan timing over one full frame.
        waitFs();
        begin
            int onCnt [NDIG];
            int gapCnt, fsAt;
            for (int k = 0; k < NDIG; k++) onCnt[k] = 0;
            gapCnt = 0;
            fsAt   = -1;
            for (int j = 1; j <= FRAME; j++) begin
                tick();
                if (bus.dig == 4'b0000) gapCnt++;
                for (int k = 0; k < NDIG; k++) if (bus.dig == 4'(1 << k)) onCnt[k]++;
                if (j == 3)  check("scan_first_dig0", 32'(bus.dig), 32'b0001);
                if (j == 19) check("scan_first_dig1", 32'(bus.dig), 32'b0010);
                if (j == 35) check("scan_first_dig2", 32'(bus.dig), 32'b0100);
                if (j == 51) check("scan_first_dig3", 32'(bus.dig), 32'b1000);
                if (bus.frame_start && fsAt < 0) fsAt = j;
            end
            for (int k = 0; k < NDIG; k++) check("scan_on_len", 32'(onCnt[k]), 32'(SLOT - BLANK_CYC));
            check("scan_gap_len",     32'(gapCnt), 32'(NDIG * BLANK_CYC));
            check("frame_start_period", 32'(fsAt), 32'(FRAME));
        end

        // Table of loaded values and the frame they must produce.
        for (int v = 0; v < 7; v++) begin
            waitFs();
            doLoad(tbl[v].bcd, tbl[v].dp);
            check("tbl_pending_set", 32'(bus.pending), 32'd1);
            waitFs();
            check("tbl_pending_clr", 32'(bus.pending), 32'd0);
            for (int j = 1; j <= 3 * SLOT + 9; j++) begin
                tick();
                if ((j % SLOT) == 9) begin
                    int s;
                    s = j / SLOT;
                    check("tbl_dig", 32'(bus.dig), 32'(1 << s));
`ifdef LEADING_ZERO_BLANK_EN
                    check("tbl_seg", 32'(segNow()), 32'(tbl[v].segL[s]));
`else
                    check("tbl_seg", 32'(segNow()), 32'(tbl[v].segP[s]));
`endif
                    check("tbl_segDP", 32'(bus.segDP), 32'(tbl[v].dp[s]));
                end
            end
        end

        // Last of several loads wins; a load on the boundary edge waits a frame.
        waitFs();
        doLoad(16'h1111, 4'b0000);
        repeat (5) tick();
        doLoad(16'h5678, 4'b0000);
        waitFs();
        repeat (9) tick();
        check("overwrite_dig0", 32'(segNow()), 32'b1111111);
        doLoad(16'h1234, 4'b0000);
        while ((pos % FRAME) != FRAME - 1) tick();
        doLoad(16'h9999, 4'b0000);
        check("boundary_fs",      32'(bus.frame_start), 32'd1);
        check("boundary_pending", 32'(bus.pending),     32'd1);
        repeat (9) tick();
        check("boundary_prior_shown", 32'(segNow()), 32'b0110011);
        waitFs();
        check("boundary_pending_clr", 32'(bus.pending), 32'd0);
        repeat (9) tick();
        check("boundary_new_shown", 32'(segNow()), 32'b1111011);

        // Random loads, values (including illegal nibbles) and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            RST        = ($urandom_range(0, 499) == 0);
            bus.load   = ($urandom_range(0, 9) == 0);
            bus.bcd_in = 16'($urandom);
            bus.dp_in  = 4'($urandom);
            tick();
        end
        RST      = 1'b0;
        bus.load = 1'b0;
        repeat (FRAME) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
